signed_vector_divider_iter: RTL
===============================

# signed_vector_divider_iter

Parametrised, iterative signed fixed-point 3-component vector divider with valid/ready handshaking. Each component is stored as {sign, integer magnitude, fraction magnitude}. The block computes out = in_vector_1 / in_vector_2 component-wise, using one restoring-division step per cycle on three parallel datapaths. It flags divide-by-zero and saturates on overflow. It serves the ray-tracing datapath wherever division is needed with a variable Q-format or a short combinational path.

## Interface
- INT_BITS, 8, integer magnitude bits per component
- FRAC_BITS, 10, fraction bits per component; the dividend is pre-shifted left by this amount
- Derived, not overridable:
  - MAG_W = INT_BITS+FRAC_BITS (18)
  - COMP_W = MAG_W+1 (19)
  - VEC_W = 3*COMP_W (57)
  - N = MAG_W+FRAC_BITS (28 iterations)

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands are present
- in_ready  out  1  block accepts operands this cycle
- in_vector_1  in  VEC_W  dividend; x at [VEC_W-1 -: COMP_W], then y, then z at [COMP_W-1:0]
- in_vector_2  in  VEC_W  divisor; same layout as in_vector_1
- out_valid  out  1  result is present
- out_ready  in  1  downstream accepts the result
- out_vector  out  VEC_W  quotient; same layout as the inputs
- out_dz  out  3  divide-by-zero flags; bit2=x, bit1=y, bit0=z
- out_ovf  out  3  saturation flags; same bit order as out_dz

## Operation
States:
- IDLE: in_ready=1. On in_valid, latch the operands, clear the iteration counter, go to BUSY.
- BUSY: in_ready=0. Each cycle, every lane performs one restoring step on dividend (|a| << FRAC_BITS, width N) by |b| (width MAG_W). On the N-th step, go to DONE.
- DONE: out_valid=1. Outputs are held stable until out_ready=1; on that edge go to IDLE.

Per-lane rules:
- Sign = a_sign XOR b_sign.
- Quotient magnitude q is N bits wide.
- If q >= 2^MAG_W: output magnitude = all ones (2^MAG_W - 1) and ovf=1.
- If |b| == 0: magnitude = all ones, sign = a_sign, dz=1, ovf=0. This takes priority over the overflow check.
- If the final magnitude is 0, sign is forced to 0. Negative zero is never emitted.
- Flags are valid only while out_valid=1 and update together with out_vector.

General rules:
- Inputs are latched at acceptance, so later changes on the input buses have no effect.
- in_valid while BUSY or DONE is ignored. in_ready=0 there, so upstream holds its data.
- There is no combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Timing
- Reset values: in_ready=0 during the reset cycle, then 1. out_valid=0, out_vector=0, out_dz=0, out_ovf=0. State is IDLE.
- rst asserted in any state, including mid-BUSY, aborts the operation:
  - on the next edge all outputs take their reset values and the in-flight result is discarded;
  - in_ready=1 on the first cycle after rst deasserts.
- Latency: if the accept edge is edge 0, out_valid is 1 after edge N (28 by default).
- Throughput: one operation per N+2 cycles (accept, N steps, handshake out). in_ready returns to 1 the cycle after the out handshake.
- If out_ready is already high when out_valid rises, the result is present for exactly one cycle.
- Flags and out_vector change only on the edge that enters DONE and on reset. They hold their last values in IDLE and BUSY, but are meaningful only while out_valid=1.

## Test plan
Examples use default parameters: 1.0 = 0x00400 per component; the sign bit is bit 18.

1. Basic signs.
   - Stimulus: x = 3.0/1.5 (0x00C00/0x00600), y = -1.0/0.5 (0x40400/0x00200), z = 1.0/-4.0 (0x00400/0x41000).
   - Required: out x=0x00800, y=0x40800, z=0x40100, out_dz=0, out_ovf=0.
   - Required: out_valid rises exactly 28 cycles after the accept edge.
2. Divide by zero.
   - Stimulus: z = -5.0/0 (0x41400/0x00000), x and y = 1.0/1.0.
   - Required: z = 0x7FFFF, out_dz=3'b001; x and y = 0x00400.
   - Also cover +0/0: required z = 0x3FFFF, dz=1.
3. Overflow.
   - Stimulus: x = 200.0/(1/1024) (0x32000/0x00001).
   - Required: x = 0x3FFFF, out_ovf=3'b100.
   - Stimulus: x = 255.0/1.0.
   - Required: 0x3FC00, ovf=0.
4. Negative zero.
   - Stimulus: y = 0/-2.0 (0x00000/0x40800).
   - Required: y = 0x00000, sign 0.
   - Stimulus: tiny/huge, 0x00001/0x3FC00.
   - Required: magnitude truncates to 0, output 0x00000.
5. Backpressure.
   - Stimulus: hold out_ready=0 for 5 cycles after out_valid, and toggle in_valid and the input buses meanwhile.
   - Required: out_vector and flags stable, in_ready=0, no second accept.
   - On out_ready=1: out_valid=0 next cycle, in_ready=1. A back-to-back second operation produces its correct result.
6. Reset mid-operation.
   - Stimulus: assert rst for 1 cycle on the 10th BUSY cycle.
   - Required: the next cycle has out_valid=0, all outputs 0, and in_ready=1 once rst is low.
   - A following 6.0/2.0 operation returns 0x00C00 with full 28-cycle latency.

Source files
------------

// File: rtl/signed_vector_divider_iter.sv
// rtl/signed_vector_divider_iter.sv - iterative signed fixed-point 3-lane vector divider
// Three restoring dividers run in lockstep, retiring one quotient bit per cycle.
module signed_vector_divider_iter #(
  parameter int INT_BITS  = 8,
  parameter int FRAC_BITS = 10
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [3*(INT_BITS+FRAC_BITS+1)-1:0]        in_vector_1,
  input  logic [3*(INT_BITS+FRAC_BITS+1)-1:0]        in_vector_2,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [3*(INT_BITS+FRAC_BITS+1)-1:0]        out_vector,
  output logic [2:0]                                 out_dz,
  output logic [2:0]                                 out_ovf
);

  localparam int MAG_W  = INT_BITS + FRAC_BITS;
  localparam int COMP_W = MAG_W + 1;
  localparam int VEC_W  = 3 * COMP_W;
  localparam int N      = MAG_W + FRAC_BITS;
  localparam int CNT_W  = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                   state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic [VEC_W-1:0]         out_vector_q;
  logic [2:0]               out_dz_q;
  logic [2:0]               out_ovf_q;

  // quo_q starts as the shifted dividend; quotient bits shift in from the bottom.
  logic [2:0][N-1:0]        quo_q, quo_d;
  logic [2:0][MAG_W-1:0]    rem_q, rem_d;
  logic [2:0][MAG_W-1:0]    bmag_q;
  logic [2:0]               asign_q, bsign_q;

  logic [2:0][MAG_W:0]      trial;
  logic [2:0]               ge;
  logic [2:0][MAG_W-1:0]    mag;
  logic [2:0]               sgn;
  logic [2:0][COMP_W-1:0]   res_d;
  logic [2:0]               dz_d, ovf_d;

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_vector = out_vector_q;
  assign out_dz     = out_dz_q;
  assign out_ovf    = out_ovf_q;

  always_comb begin
    trial = '0;
    ge    = '0;
    rem_d = '0;
    quo_d = '0;
    mag   = '0;
    sgn   = '0;
    dz_d  = '0;
    ovf_d = '0;
    res_d = '0;
    for (int i = 0; i < 3; i++) begin
      trial[i] = {rem_q[i], quo_q[i][N-1]};
      ge[i]    = trial[i] >= {1'b0, bmag_q[i]};
      rem_d[i] = ge[i] ? MAG_W'(trial[i] - {1'b0, bmag_q[i]}) : trial[i][MAG_W-1:0];
      quo_d[i] = {quo_q[i][N-2:0], ge[i]};
      // Divide-by-zero wins over overflow and keeps the dividend's sign.
      dz_d[i]  = (bmag_q[i] == '0);
      ovf_d[i] = !dz_d[i] && (quo_d[i][N-1:MAG_W] != '0);
      mag[i]   = (dz_d[i] || ovf_d[i]) ? '1 : quo_d[i][MAG_W-1:0];
      sgn[i]   = dz_d[i] ? asign_q[i] : (asign_q[i] ^ bsign_q[i]);
      res_d[i] = {sgn[i] && (mag[i] != '0), mag[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_vector_q <= '0;
      out_dz_q     <= '0;
      out_ovf_q    <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      bmag_q       <= '0;
      asign_q      <= '0;
      bsign_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            for (int i = 0; i < 3; i++) begin
              asign_q[i] <= in_vector_1[i*COMP_W + MAG_W];
              bsign_q[i] <= in_vector_2[i*COMP_W + MAG_W];
              bmag_q[i]  <= in_vector_2[i*COMP_W +: MAG_W];
              quo_q[i]   <= {in_vector_1[i*COMP_W +: MAG_W], {FRAC_BITS{1'b0}}};
            end
            rem_q      <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          quo_q <= quo_d;
          rem_q <= rem_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            state_q      <= DONE;
            out_valid_q  <= 1'b1;
            out_vector_q <= res_d;
            out_dz_q     <= dz_d;
            out_ovf_q    <= ovf_d;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
